// File: rtl/feature_frame_packer.sv
// Stream front end for the combinational classifier: packs NUM_A features
// into clf_inp, waits SETTLE clocks, then hands the result out with an index.
module feature_frame_packer #(
    parameter int OUTWIDTH = 2,
    parameter int NUM_A    = 8,
    parameter int WIDTH_A  = 4,
    parameter int SETTLE   = 1,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH_A-1:0]         s_data,
    input  logic                       s_last,
    output logic [NUM_A*WIDTH_A-1:0]   clf_inp,
    input  logic [OUTWIDTH-1:0]        clf_out,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OUTWIDTH-1:0]        m_data,
    output logic [CNT_W-1:0]           m_index,
    output logic                       err
);

    localparam int IW = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam int SW = $clog2(SETTLE) + 1;

    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [SW-1:0] cnt;
    logic          accept;
    logic          at_end;

    assign accept = s_valid && s_ready;
    assign at_end = (idx == IW'(NUM_A - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            idx     <= '0;
            cnt     <= '0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_index <= '0;
            clf_inp <= '0;
            err     <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        clf_inp[idx*WIDTH_A +: WIDTH_A] <= s_data;
                        if (at_end) begin
                            // Frame is full; a missing s_last is flagged
                            // but the frame is still classified.
                            state   <= WAIT;
                            cnt     <= SW'(SETTLE - 1);
                            s_ready <= 1'b0;
                            idx     <= '0;
                            if (!s_last) begin
                                err <= 1'b1;
                            end
                        end else if (s_last) begin
                            // Short frame: drop it, stale slices get
                            // overwritten by the next frame.
                            err <= 1'b1;
                            idx <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        m_data  <= clf_out;
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                OUT: begin
                    if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        m_index <= m_index + 1'b1;
                        idx     <= '0;
                        s_ready <= 1'b1;
                        state   <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feature_frame_packer.sv
// Directed bench for feature_frame_packer: a default instance and a
// SETTLE=4 / CNT_W=2 instance, checked against a frame-level result queue.
module tb_feature_frame_packer;

    typedef struct {
        logic [1:0]  d;
        logic [15:0] i;
        logic [31:0] bus;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    logic        sel = 1'b0;
    logic        s_valid = 1'b0;
    logic [3:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b0;

    logic        a_s_ready, a_m_valid, a_err;
    logic [31:0] a_clf_inp;
    logic [1:0]  a_clf_out, a_m_data;
    logic [15:0] a_m_index;

    logic        b_s_ready, b_m_valid, b_err;
    logic [31:0] b_clf_inp;
    logic [1:0]  b_clf_out, b_m_data;
    logic [1:0]  b_m_index;

    logic        c_sr, c_mv, c_err, c_rst;
    logic [1:0]  c_md;
    logic [15:0] c_mi;
    logic [31:0] c_bus;

    exp_t        q[$];
    logic [15:0] exp_idx = '0;
    logic [15:0] idx_mask = 16'hFFFF;
    int          checks = 0;
    int          errors = 0;

    logic        stall_p = 1'b0;
    logic [1:0]  hd;
    logic [15:0] hi;
    logic [31:0] hb;

    always #5 clk = ~clk;

    // Stub classifier: sum of the eight features modulo 4.
    function automatic logic [1:0] stub(input logic [31:0] bus);
        int s;
        s = 0;
        for (int k = 0; k < 8; k++) s += int'(bus[k*4 +: 4]);
        return 2'(s % 4);
    endfunction

    assign a_clf_out = stub(a_clf_inp);
    assign b_clf_out = stub(b_clf_inp);

    feature_frame_packer dut_a (
        .clk(clk), .rst_n(rst_a),
        .s_valid(s_valid), .s_ready(a_s_ready),
        .s_data(s_data), .s_last(s_last),
        .clf_inp(a_clf_inp), .clf_out(a_clf_out),
        .m_valid(a_m_valid), .m_ready(m_ready),
        .m_data(a_m_data), .m_index(a_m_index),
        .err(a_err)
    );

    feature_frame_packer #(.SETTLE(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_b),
        .s_valid(s_valid), .s_ready(b_s_ready),
        .s_data(s_data), .s_last(s_last),
        .clf_inp(b_clf_inp), .clf_out(b_clf_out),
        .m_valid(b_m_valid), .m_ready(m_ready),
        .m_data(b_m_data), .m_index(b_m_index),
        .err(b_err)
    );

    always_comb begin
        c_sr  = sel ? b_s_ready : a_s_ready;
        c_mv  = sel ? b_m_valid : a_m_valid;
        c_err = sel ? b_err : a_err;
        c_rst = sel ? rst_b : rst_a;
        c_md  = sel ? b_m_data : a_m_data;
        c_mi  = sel ? {14'd0, b_m_index} : a_m_index;
        c_bus = sel ? b_clf_inp : a_clf_inp;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp();
        exp_t e;
        if (c_mv && m_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("m_data", 32'(c_md), 32'(e.d));
                chk("m_index", 32'(c_mi), 32'(e.i));
                chk("clf_inp", c_bus, e.bus);
            end
        end
        if (stall_p && c_rst) begin
            chk("hold_valid", 32'(c_mv), 32'd1);
            chk("hold_data", 32'(c_md), 32'(hd));
            chk("hold_index", 32'(c_mi), 32'(hi));
            chk("hold_clf_inp", c_bus, hb);
        end
    endtask

    always @(negedge clk) begin
        cmp();
        stall_p <= c_mv && !m_ready && c_rst;
        hd <= c_md;
        hi <= c_mi;
        hb <= c_bus;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] vals, input int n,
                        input int lastk, input int gap);
        int sum;
        bit acc;
        sum = 0;
        for (int k = 0; k < n; k++) begin
            s_valid = 1'b1;
            s_data  = vals[k*4 +: 4];
            s_last  = (k == lastk);
            sum += int'(vals[k*4 +: 4]);
            acc = 1'b0;
            for (int t = 0; t < 40 && !acc; t++) begin
                acc = c_sr;
                tick();
            end
            if (!acc) chk("accept_timeout", 32'd0, 32'd1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (k == 7) begin
                q.push_back('{2'(sum % 4), exp_idx, vals});
                exp_idx = (exp_idx + 16'd1) & idx_mask;
            end
            if (k < n - 1) repeat (gap) tick();
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && q.size() > 0; t++) tick();
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        bit seen;
        // Reset state of instance A
        repeat (3) tick();
        chk("rst_s_ready", 32'(a_s_ready), 32'd0);
        chk("rst_m_valid", 32'(a_m_valid), 32'd0);
        chk("rst_m_data", 32'(a_m_data), 32'd0);
        chk("rst_m_index", 32'(a_m_index), 32'd0);
        chk("rst_clf_inp", a_clf_inp, 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        rst_a = 1'b1;
        tick();
        chk("s_ready_after_rst", 32'(a_s_ready), 32'd1);

        // First frame, then backpressure for five clocks
        send(32'h87654321, 8, 7, 0);
        chk("wait_no_valid", 32'(c_mv), 32'd0);
        chk("wait_s_ready", 32'(c_sr), 32'd0);
        tick();
        chk("f1_valid", 32'(c_mv), 32'd1);
        chk("f1_clf_inp", c_bus, 32'h87654321);
        chk("f1_m_data", 32'(c_md), 32'd0);
        chk("f1_m_index", 32'(c_mi), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_s_ready", 32'(c_sr), 32'd0);
        end
        m_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(c_mv), 32'd0);
        chk("bp_release_index", 32'(c_mi), 32'd1);
        chk("bp_release_s_ready", 32'(c_sr), 32'd1);

        // Same frame with gaps, then a second pattern
        send(32'h87654321, 8, 7, 2);
        drain();
        send(32'h00000123, 8, 7, 0);
        drain();

        // Short frame is dropped and flags err
        send(32'h00000321, 3, 2, 0);
        repeat (4) tick();
        chk("short_no_valid", 32'(c_mv), 32'd0);
        chk("short_err", 32'(c_err), 32'd1);
        send(32'h11111112, 8, 7, 0);
        drain();
        chk("err_sticky", 32'(c_err), 32'd1);
        chk("a_index", 32'(a_m_index), 32'd4);

        // Switch to instance B (SETTLE=4, CNT_W=2)
        rst_a = 1'b0;
        sel = 1'b1;
        idx_mask = 16'h0003;
        exp_idx = '0;
        tick();
        chk("b_rst_s_ready", 32'(b_s_ready), 32'd0);
        chk("b_rst_m_valid", 32'(b_m_valid), 32'd0);
        chk("b_rst_clf_inp", b_clf_inp, 32'd0);
        rst_b = 1'b1;
        tick();
        chk("b_s_ready_after_rst", 32'(b_s_ready), 32'd1);

        // Frame without s_last, reset while settling
        send(32'hFEDCBA98, 8, -1, 0);
        chk("b_missing_last_err", 32'(b_err), 32'd1);
        repeat (2) tick();
        chk("b_wait_no_valid", 32'(b_m_valid), 32'd0);
        rst_b = 1'b0;
        q.delete();
        exp_idx = '0;
        #1;
        chk("b_midrst_valid", 32'(b_m_valid), 32'd0);
        chk("b_midrst_index", 32'(b_m_index), 32'd0);
        chk("b_midrst_err", 32'(b_err), 32'd0);
        tick();
        rst_b = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (b_m_valid) seen = 1'b1;
        end
        chk("b_no_valid_after_rst", 32'(seen), 32'd0);

        // Five frames: index wraps 0,1,2,3,0
        send(32'h12345678, 8, 7, 0);
        send(32'h00000001, 8, 7, 0);
        send(32'h22222222, 8, 7, 1);
        send(32'h0000F00F, 8, 7, 0);
        send(32'h33333333, 8, 7, 0);
        drain();
        chk("b_index_wrap", 32'(b_m_index), 32'd1);
        chk("b_err_clear", 32'(b_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
